// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART encodings: receiver/transmitter FSM states and oversampling constants.
package uart_rx_buffer_pkg;

  localparam int         OS_RATE   = 16;
  localparam logic [3:0] MID_PHASE = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int os_div(input int clk_freq, input int baud);
    return (clk_freq + (OS_RATE * baud) / 2) / (OS_RATE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// Show-ahead FIFO: head word is visible on rd_data while not empty, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_10M,
  input  logic                     reset_of_clk10M,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_10M) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Oversampled 8N1 receiver feeding a show-ahead byte FIFO with sticky overrun/frame flags.
// Define UART_RX_PARITY_EN for 8E1 frames (adds the PARITY state and check).
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_10M,
  input  logic                          reset_of_clk10M,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          data_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err
);

  // states: IDLE wait falling edge | START confirm start bit | DATA 8 bits LSB first |
  //         PARITY even-parity bit | STOP check stop, push | BREAK wait line high
  localparam int            OS_DIV    = os_div(CLK_FREQ, BAUD);
  localparam int            TW        = $clog2(OS_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS_DIV - 1);

  rx_state_t     state, state_nx;
  logic          rxd_m, rxd_s, rxd_d;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          os_tick, mid;
  logic          push, push_ok, set_ferr, shift_en;
  logic          fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign os_tick = (state != ST_IDLE) && (tick_cnt == TICK_LAST);
  assign mid     = os_tick && (phase == MID_PHASE);

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else if (state == ST_IDLE) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else begin
      tick_cnt <= os_tick ? '0 : tick_cnt + 1'b1;
      if (os_tick) phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) state <= ST_IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    set_ferr = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_IDLE:  if (rxd_d && !rxd_s) state_nx = ST_START;
      ST_START: if (mid) state_nx = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (mid) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
`else
          if (bit_cnt == 3'd7) state_nx = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid) begin
          set_ferr = (rxd_s != ^shreg);
          state_nx = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (mid) begin
          if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
            state_nx = ST_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_nx = ST_BREAK;
          end
        end
      end
      ST_BREAK: if (rxd_s) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == ST_IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M)                 par_bad <= 1'b0;
    else if (state == ST_IDLE)           par_bad <= 1'b0;
    else if (state == ST_PARITY && mid)  par_bad <= (rxd_s != ^shreg);
  end
`endif

  // Set events take priority over clr_err in the same cycle.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && !push_ok) overrun <= 1'b1;
      else if (clr_err)     overrun <= 1'b0;
      if (set_ferr)         frame_err <= 1'b1;
      else if (clr_err)     frame_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_10M         (clk_10M),
    .reset_of_clk10M (reset_of_clk10M),
    .push            (push),
    .wr_data         (shreg),
    .pop             (rd_en),
    .rd_data         (rd_data),
    .empty           (fifo_empty),
    .full            (fifo_full),
    .count           (fifo_count),
    .push_ok         (push_ok)
  );

  assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomised frame-level bench for uart_rx_buffer with a queue model of the FIFO and flags.
`timescale 1ns/1ps
module tb_uart_rx_buffer;

  localparam int  CLK_FREQ = 10_000_000;
  // Fast line keeps the run short: 10e6 / (16 * 156250) = 4 clocks per oversample tick.
  localparam int  BAUD   = 156_250;
  localparam int  OS     = 4;
  localparam int  DEPTH  = 16;
  localparam time BIT_NS = 6400;
`ifdef UART_RX_PARITY_EN
  localparam int  STOP_IDX = 10;
`else
  localparam int  STOP_IDX = 9;
`endif
  // rxd falls just after edge P0; 2 sync stages + edge detect put START at P0+3, and the
  // stop bit is sampled on tick 8+16*STOP_IDX, registering at this edge offset.
  localparam int  PUSH_EDGE = 3 + OS * (8 + 16 * STOP_IDX);

  logic       clk_10M, reset_of_clk10M, rxd, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       data_valid, fifo_full, overrun, frame_err;
  logic [4:0] fifo_count;

  int         tests, fails;
  logic [7:0] q[$];
  bit         m_ovr, m_ferr, quiet;

  uart_rx_buffer #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_10M         (clk_10M),
    .reset_of_clk10M (reset_of_clk10M),
    .rxd             (rxd),
    .rd_en           (rd_en),
    .clr_err         (clr_err),
    .rd_data         (rd_data),
    .data_valid      (data_valid),
    .fifo_full       (fifo_full),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .frame_err       (frame_err)
  );

  initial clk_10M = 1'b0;
  always #50 clk_10M = ~clk_10M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_10M) begin
    if (quiet) begin
      check("data_valid", data_valid, q.size() != 0);
      check("rd_data", rd_data, (q.size() != 0) ? q[0] : 8'h00);
      check("fifo_count", fifo_count, q.size());
      check("fifo_full", fifo_full, q.size() == DEPTH);
      check("overrun", overrun, m_ovr);
      check("frame_err", frame_err, m_ferr);
    end
  end

  function automatic void m_push(input logic [7:0] b);
    if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input time extra_ns,
                            input logic par_flip);
    quiet = 1'b0;
    @(posedge clk_10M);
    #1 rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    #(BIT_NS);
`endif
    rxd = stop_bit;
    #(BIT_NS);
    if (extra_ns > 0) #(extra_ns);
    rxd = 1'b1;
    #(BIT_NS);
  endtask

  task automatic settle();
    quiet = 1'b1;
    repeat (6) @(posedge clk_10M);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 0, 1'b0);
    m_push(b);
    settle();
  endtask

  task automatic pop_one();
    @(negedge clk_10M);
    rd_en = 1'b1;
    @(posedge clk_10M);
    #1 rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_err();
    @(negedge clk_10M);
    clr_err = 1'b1;
    @(posedge clk_10M);
    #1 clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; quiet = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    reset_of_clk10M = 1'b1;
    repeat (3) @(negedge clk_10M);
    check("reset data_valid", data_valid, 0);
    check("reset rd_data", rd_data, 8'h00);
    check("reset count", fifo_count, 0);
    check("reset flags", {overrun, frame_err, fifo_full}, 3'b000);
    reset_of_clk10M = 1'b0;
    settle();

    // two bytes, show-ahead pops
    send_good(8'h55);
    send_good(8'hA3);
    check("t1 head", rd_data, 8'h55);
    check("t1 count", fifo_count, 2);
    pop_one(); settle();
    check("t1 second", rd_data, 8'hA3);
    pop_one(); settle();
    check("t1 drained", data_valid, 0);
    pop_one(); settle();
    check("t1 pop empty count", fifo_count, 0);

    // short low glitch is ignored
    quiet = 1'b0;
    @(posedge clk_10M);
    #1 rxd = 1'b0;
    #(BIT_NS / 5) rxd = 1'b1;
    #(BIT_NS * 2);
    settle();
    check("t2 frame_err", frame_err, 0);
    check("t2 count", fifo_count, 0);

    // bad stop bit with line held low; clr_err in the same cycle loses
    fork
      send_frame(8'h7E, 1'b0, BIT_NS / 2, 1'b0);
      begin
        repeat (PUSH_EDGE) @(posedge clk_10M);
        #1 clr_err = 1'b1;
        @(posedge clk_10M);
        #1 clr_err = 1'b0;
      end
    join
    m_ferr = 1'b1;
    settle();
    check("t3 frame_err", frame_err, 1);
    check("t3 count", fifo_count, 0);
    clear_err(); settle();
    check("t3 cleared", frame_err, 0);
    send_good(8'h11);
    check("t3 next byte", rd_data, 8'h11);
    pop_one(); settle();

    // fill past depth
    for (int i = 0; i < 17; i++) send_good(8'(i));
    check("t4 full", fifo_full, 1);
    check("t4 count", fifo_count, 16);
    check("t4 overrun", overrun, 1);
    check("t4 head", rd_data, 8'h00);
    clear_err(); settle();

    // push into full FIFO with rd_en on the push cycle
    fork
      send_frame(8'hB7, 1'b1, 0, 1'b0);
      begin
        repeat (PUSH_EDGE) @(posedge clk_10M);
        #1 rd_en = 1'b1;
        @(posedge clk_10M);
        #1 rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'hB7);
    settle();
    check("t5 count", fifo_count, 16);
    check("t5 overrun", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      check("t4 pop order", rd_data, (i < 15) ? 8'(i + 1) : 8'hB7);
      pop_one();
    end
    settle();
    check("t4 empty", data_valid, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 0, 1'b1);
    m_ferr = 1'b1;
    settle();
    check("par bad frame_err", frame_err, 1);
    check("par bad count", fifo_count, 0);
    clear_err(); settle();
    send_good(8'h03);
    check("par good", rd_data, 8'h03);
    pop_one(); settle();
`endif

    // random bytes with random pops
    for (int n = 0; n < 10; n++) begin
      send_good(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) pop_one();
      settle();
    end
    while (q.size() > 3) pop_one();
    while (q.size() < 3) send_good(8'($urandom_range(0, 255)));
    settle();
    check("t6 queued", fifo_count, 3);

    // reset in the middle of DATA of 0xC4
    quiet = 1'b0;
    @(negedge clk_10M);
    fork
      send_frame(8'hC4, 1'b1, 0, 1'b0);
      begin
        #(BIT_NS * 4 + BIT_NS / 2) reset_of_clk10M = 1'b1;
        #100;
        check("t6 reset count", fifo_count, 0);
        check("t6 reset valid", data_valid, 0);
        check("t6 reset rd_data", rd_data, 8'h00);
        check("t6 reset flags", {overrun, frame_err, fifo_full}, 3'b000);
        #(BIT_NS * 3 - 100) reset_of_clk10M = 1'b0;
      end
    join
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    settle();
    send_good(8'h5A);
    check("t6 next byte", rd_data, 8'h5A);
    check("t6 next count", fifo_count, 1);
    pop_one(); settle();
    quiet = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
